// File: rtl/crc32_slice4_engine.sv
// Slicing-by-4 reflected CRC-32 engine driving four external 256x32 lookup tables.
// Full words use all four lanes in one cycle; a 1-3 byte tail finishes byte-serially on lane 0.
//
// state | meaning
// IDLE  | no frame in progress, crc holds CRC_INIT
// RUN   | at least one non-last word of the frame absorbed
// TAIL  | draining the latched partial last word one byte per cycle
module crc32_slice4_engine #(
   parameter logic [31:0] CRC_INIT   = 32'hFFFF_FFFF,
   parameter logic [31:0] CRC_XOROUT = 32'hFFFF_FFFF
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         s_valid,
   output logic         s_ready,
   input  logic [31:0]  s_data,
   input  logic         s_last,
   input  logic [1:0]   s_nbytes,
   output logic [31:0]  tbl_addr,
   input  logic [127:0] tbl_rdata,
   output logic         crc_valid,
   output logic [31:0]  crc_out,
   output logic         busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      TAIL = 2'd2
   } state_t;

   state_t      state, state_nx;
   logic [31:0] crc, crc_nx;
   logic [23:0] tail_word, tail_nx;
   logic [1:0]  tail_cnt, cnt_nx;
   logic [31:0] out_nx;
   logic        valid_nx;

   logic        accept;
   logic        partial;
   logic [31:0] x;
   logic [31:0] word_crc;
   logic [31:0] tail_crc;

   assign s_ready  = !rst && (state == IDLE || state == RUN);
   assign accept   = s_valid && s_ready;
   assign partial  = s_last && (s_nbytes != 2'd0);
   assign busy     = (state != IDLE);
   assign x        = crc ^ s_data;

   assign word_crc = tbl_rdata[127:96] ^ tbl_rdata[95:64] ^ tbl_rdata[63:32] ^ tbl_rdata[31:0];
   assign tail_crc = (crc >> 8) ^ tbl_rdata[31:0];

   // Lane 3 (table T3) takes the oldest byte, lane 0 (T0) the newest.
   always_comb begin
      tbl_addr = '0;
      if (state == TAIL) begin
         tbl_addr[7:0] = crc[7:0] ^ tail_word[7:0];
      end else if (accept && !partial) begin
         tbl_addr = {x[7:0], x[15:8], x[23:16], x[31:24]};
      end
   end

   always_comb begin
      state_nx = state;
      crc_nx   = crc;
      tail_nx  = tail_word;
      cnt_nx   = tail_cnt;
      out_nx   = crc_out;
      valid_nx = 1'b0;
      case (state)
         IDLE, RUN: begin
            if (accept) begin
               if (partial) begin
                  tail_nx  = s_data[23:0];
                  cnt_nx   = s_nbytes;
                  state_nx = TAIL;
               end else if (s_last) begin
                  out_nx   = word_crc ^ CRC_XOROUT;
                  valid_nx = 1'b1;
                  crc_nx   = CRC_INIT;
                  state_nx = IDLE;
               end else begin
                  crc_nx   = word_crc;
                  state_nx = RUN;
               end
            end
         end
         TAIL: begin
            tail_nx = tail_word >> 8;
            cnt_nx  = tail_cnt - 2'd1;
            if (tail_cnt == 2'd1) begin
               out_nx   = tail_crc ^ CRC_XOROUT;
               valid_nx = 1'b1;
               crc_nx   = CRC_INIT;
               state_nx = IDLE;
            end else begin
               crc_nx = tail_crc;
            end
         end
         default: begin
            crc_nx   = CRC_INIT;
            state_nx = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         crc       <= CRC_INIT;
         tail_word <= '0;
         tail_cnt  <= '0;
         crc_out   <= '0;
         crc_valid <= 1'b0;
      end else begin
         state     <= state_nx;
         crc       <= crc_nx;
         tail_word <= tail_nx;
         tail_cnt  <= cnt_nx;
         crc_out   <= out_nx;
         crc_valid <= valid_nx;
      end
   end

endmodule

// File: tb/tb_crc32_slice4_engine.sv
// Bench for crc32_slice4_engine: table model on the lookup port, directed frames,
// expected CRCs queued by the driver and checked by an independent monitor.
module tb_crc32_slice4_engine;

   logic         clk = 1'b0;
   logic         rst;
   logic         s_valid;
   logic         s_ready;
   logic [31:0]  s_data;
   logic         s_last;
   logic [1:0]   s_nbytes;
   logic [31:0]  tbl_addr;
   logic [127:0] tbl_rdata;
   logic         crc_valid;
   logic [31:0]  crc_out;
   logic         busy;

   crc32_slice4_engine dut (
      .clk       (clk),
      .rst       (rst),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .s_data    (s_data),
      .s_last    (s_last),
      .s_nbytes  (s_nbytes),
      .tbl_addr  (tbl_addr),
      .tbl_rdata (tbl_rdata),
      .crc_valid (crc_valid),
      .crc_out   (crc_out),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   logic [31:0] t0 [256];
   logic [31:0] t1 [256];
   logic [31:0] t2 [256];
   logic [31:0] t3 [256];

   assign tbl_rdata = {t3[tbl_addr[31:24]], t2[tbl_addr[23:16]],
                       t1[tbl_addr[15:8]],  t0[tbl_addr[7:0]]};

   typedef struct {
      logic [31:0] crc;
      int          due;
   } exp_t;

   exp_t sb[$];
   int   pass_cnt  = 0;
   int   total_cnt = 0;
   int   cyc       = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Monitor: pops one expectation per crc_valid pulse, checks value and arrival cycle.
   always @(negedge clk) begin
      exp_t e;
      cyc++;
      if (crc_valid === 1'b1) begin
         if (sb.size() == 0) begin
            total_cnt++;
            $display("FAIL unexpected_pulse: got crc_out %h with no frame pending", crc_out);
         end else begin
            e = sb.pop_front();
            check("crc_out", crc_out, e.crc);
            check("valid_cycle", cyc, e.due);
         end
      end
   end

   task automatic send_word(input logic [31:0] d, input bit last, input logic [1:0] nb,
                            input logic [31:0] exp, input bit push, output int stalls);
      stalls   = 0;
      s_valid  = 1'b1;
      s_data   = d;
      s_last   = last;
      s_nbytes = nb;
      while (!s_ready && stalls < 20) begin
         @(negedge clk);
         stalls++;
      end
      check("accept_ready", {31'd0, s_ready}, 32'd1);
      @(posedge clk);
      if (last && push) sb.push_back('{exp, cyc + 1 + int'(nb)});
      @(negedge clk);
      s_valid  = 1'b0;
      s_last   = 1'b0;
      s_nbytes = 2'd0;
      s_data   = '0;
   endtask

   task automatic send_frame(input logic [31:0] w [3], input int nw, input logic [1:0] nb,
                             input logic [31:0] exp, input bit gaps, output int stalls);
      int st;
      int low;
      stalls = 0;
      for (int i = 0; i < nw; i++) begin
         if (gaps) begin
            repeat ($urandom_range(0, 3)) begin
               s_data = $urandom;
               @(negedge clk);
            end
            s_data = '0;
         end
         send_word(w[i], i == nw - 1, (i == nw - 1) ? nb : 2'd0, exp, 1'b1, st);
         stalls += st;
      end
      if (nb != 2'd0) begin
         low = 0;
         while (!s_ready && low < 10) begin
            low++;
            @(negedge clk);
         end
         check("tail_ready_low_cycles", low, int'(nb));
      end
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("drain_pending", sb.size(), 0);
   endtask

   initial begin
      int st;
      logic [31:0] c;
      for (int i = 0; i < 256; i++) begin
         c = i;
         for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
         t0[i] = c;
      end
      for (int i = 0; i < 256; i++) t1[i] = (t0[i] >> 8) ^ t0[t0[i][7:0]];
      for (int i = 0; i < 256; i++) t2[i] = (t1[i] >> 8) ^ t0[t1[i][7:0]];
      for (int i = 0; i < 256; i++) t3[i] = (t2[i] >> 8) ^ t0[t2[i][7:0]];
      check("table_t0_1", t0[1], 32'h7707_3096);

      rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; s_nbytes = 2'd0;
      repeat (3) @(negedge clk);
      check("rst_s_ready", {31'd0, s_ready}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_crc_valid", {31'd0, crc_valid}, 32'd0);
      check("rst_crc_out", crc_out, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("idle_s_ready", {31'd0, s_ready}, 32'd1);

      // "1234"
      send_frame('{32'h3433_3231, 32'h0, 32'h0}, 1, 2'd0, 32'h9BE3_E0A3, 1'b0, st);
      drain();

      // "123456789"
      send_frame('{32'h3433_3231, 32'h3837_3635, 32'h0000_0039}, 3, 2'd1, 32'hCBF4_3926, 1'b0, st);
      check("run_no_stall", st, 0);
      drain();

      // "a" and "abc"
      send_frame('{32'h0000_0061, 32'h0, 32'h0}, 1, 2'd1, 32'hE8B7_BE43, 1'b0, st);
      drain();
      send_frame('{32'h0063_6261, 32'h0, 32'h0}, 1, 2'd3, 32'h3524_41C2, 1'b0, st);
      drain();

      // Back-to-back: frame 2 starts in the cycle frame 1's pulse is high.
      send_frame('{32'h3433_3231, 32'h0, 32'h0}, 1, 2'd0, 32'h9BE3_E0A3, 1'b0, st);
      check("b2b_valid_during_start", {31'd0, crc_valid}, 32'd1);
      send_frame('{32'h3433_3231, 32'h3837_3635, 32'h0000_0039}, 3, 2'd1, 32'hCBF4_3926, 1'b0, st);
      check("b2b_no_stall", st, 0);
      drain();

      // Idle gaps with garbage data between words.
      send_frame('{32'h3433_3231, 32'h3837_3635, 32'h0000_0039}, 3, 2'd1, 32'hCBF4_3926, 1'b1, st);
      drain();
      send_frame('{32'h0063_6261, 32'h0, 32'h0}, 1, 2'd3, 32'h3524_41C2, 1'b1, st);
      drain();

      // Reset while in TAIL: frame discarded, no pulse.
      send_word(32'h3433_3231, 1'b0, 2'd0, 32'h0, 1'b0, st);
      send_word(32'h3837_3635, 1'b0, 2'd0, 32'h0, 1'b0, st);
      send_word(32'h0000_0039, 1'b1, 2'd1, 32'h0, 1'b0, st);
      check("pre_rst_busy", {31'd0, busy}, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      check("tail_rst_crc_valid", {31'd0, crc_valid}, 32'd0);
      check("tail_rst_crc_out", crc_out, 32'd0);
      check("tail_rst_busy", {31'd0, busy}, 32'd0);
      check("tail_rst_s_ready", {31'd0, s_ready}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      send_frame('{32'h3433_3231, 32'h0, 32'h0}, 1, 2'd0, 32'h9BE3_E0A3, 1'b0, st);
      drain();

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
